sync_event_scheduler: RTL and testbench
=======================================

Name: sync_event_scheduler

Overview:
- Collects single-cycle sync-detect pulses from up to NUM_PORTS per-port VLAN sync detectors.
- Timestamps each pulse against a free-running cycle counter and applies a per-port holdoff (debounce).
- Arbitrates pending events round-robin into a small event FIFO, drained over an AXI-stream-style valid/ready master.
- Sits in the 250 MHz user logic box between the per-port detectors and the clock-sync consumer.

Parameters:
- NUM_PORTS, 2, number of detector inputs (1..8)
- TS_WIDTH, 48, timestamp counter width
- HOLDOFF_CYCLES, 1024, minimum cycles between accepted events on one port (0 = no holdoff)
- FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- det_pulse_i  in  NUM_PORTS  one-cycle sync-detect pulse per port
- enable_i  in  1  global accept enable
- port_mask_i  in  NUM_PORTS  1 = port participates
- drop_clear_i  in  1  synchronous clear of drop_count_o
- m_evt_tvalid  out  1  event available
- m_evt_tdata  out  TS_WIDTH+8  [TS_WIDTH-1:0] timestamp; [TS_WIDTH+7:TS_WIDTH] port index, zero-extended
- m_evt_tready  in  1  consumer accepts
- ts_o  out  TS_WIDTH  current timestamp counter
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
- drop_count_o  out  16  saturating count of overflow drops

Behaviour:
- Reset values: ts_o=0, m_evt_tvalid=0, m_evt_tdata=0, fifo_level_o=0, drop_count_o=0. All pending flags, holdoff counters and the RR pointer clear (pointer=NUM_PORTS-1, so port 0 has first priority). Reset mid-operation discards all pending and queued events.
- Timestamp: ts increments by 1 every cycle, wraps 2^TS_WIDTH-1 -> 0.
- Capture: pulse on port p at edge t is eligible if enable_i=1 AND port_mask_i[p]=1 AND holdoff_cnt[p]=0. Else it is ignored silently (not counted).
- An eligible pulse latches ts value at cycle t into cap_ts[p] and sets pending[p] at t+1.
- It also loads holdoff_cnt[p]=HOLDOFF_CYCLES. The counter decrements each cycle to 0.
- Overflow: eligible pulse while pending[p]=1 and p not granted that cycle -> pulse dropped, drop_count_o +1 (saturate at 0xFFFF), cap_ts unchanged, holdoff still reloads.
- Simultaneous grant of p and new eligible pulse on p: old event goes to FIFO, new one captured; no drop.
- Arbiter: each cycle with FIFO not full (level<FIFO_DEPTH, counting the same-cycle pop), grant the first pending port searching from rr_ptr+1 upward with wrap. Write {p, cap_ts[p]} to FIFO, clear pending[p], set rr_ptr=p. At most one grant per cycle.
- FIFO full: no grant; pending flags hold.
- Push and pop in the same cycle is legal when full.
- Latency: pulse at edge t, idle FIFO -> pending at t+1, FIFO write at t+1, m_evt_tvalid=1 at t+2.
- Output: first-word-fall-through registered. tvalid=1 whenever level>0. tdata stable while tvalid&&!tready. Pop on tvalid&&tready.
- drop_clear_i has priority over a same-cycle increment; result 0.
- enable_i falling: pending and FIFO drain normally; only new captures are blocked. Holdoff counters keep running.
- port_mask_i bit cleared while pending: event still granted.

Test Plan:
- Single pulse port 1 at ts=100, tready=1 -> tvalid at ts=102, tdata={8'd1,48'd100}, one beat, fifo_level returns to 0.
- Pulses on ports 0 and 1 same cycle at ts=50 after reset -> port 0 event then port 1 event on consecutive cycles, both timestamped 50. Repeat -> order alternates per RR pointer.
- HOLDOFF_CYCLES=16, port 0 pulses at ts=10, 20, 27 -> events at 10 and 27 only (20 suppressed); drop_count_o=0.
- HOLDOFF_CYCLES=0, tready=0, FIFO_DEPTH=8, 10 pulses on port 0 spaced 1 cycle -> 8 queued, 1 pending, 1 dropped (drop_count_o=1). Raise tready -> 9 events in timestamp order.
- TS_WIDTH=8: pulse at ts=255 and next at ts=0 (holdoff 0) -> tdata timestamps 255 then 0.
- Reset asserted with 3 events queued and 1 pending -> tvalid=0 and level=0 immediately, ts_o=0; after release no stale events appear.

Source files
------------

// File: rtl/sync_event_scheduler.sv
// Sync event scheduler: timestamps per-port sync-detect pulses, debounces each
// port with a holdoff window, and queues events round-robin into a small
// first-word-fall-through FIFO drained over a valid/ready stream.
module sync_event_scheduler #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TS_WIDTH       = 48,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_PORTS-1:0]          det_pulse_i,
  input  logic                          enable_i,
  input  logic [NUM_PORTS-1:0]          port_mask_i,
  input  logic                          drop_clear_i,
  output logic                          m_evt_tvalid,
  output logic [TS_WIDTH+7:0]           m_evt_tdata,
  input  logic                          m_evt_tready,
  output logic [TS_WIDTH-1:0]           ts_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   drop_count_o
);

  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned HoldW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DataW = TS_WIDTH + 8;

  localparam logic [HoldW-1:0] HoldLoad  = HoldW'(HOLDOFF_CYCLES);
  localparam logic [LvlW-1:0]  DepthLvl  = LvlW'(FIFO_DEPTH);
  localparam logic [PortW-1:0] RrReset   = PortW'(NUM_PORTS - 1);

  // State
  logic [TS_WIDTH-1:0]  ts_q;
  logic [NUM_PORTS-1:0] pending_q;
  logic [TS_WIDTH-1:0]  cap_ts_q [NUM_PORTS];
  logic [HoldW-1:0]     hold_q   [NUM_PORTS];
  logic [PortW-1:0]     rr_q;
  logic [DataW-1:0]     mem_q    [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q;
  logic [AddrW-1:0]     rd_ptr_q;
  logic [LvlW-1:0]      level_q;
  logic [15:0]          drop_q;

  // Combinational
  logic [NUM_PORTS-1:0] hold_idle;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] capture;
  logic [NUM_PORTS-1:0] drop_vec;
  logic [NUM_PORTS-1:0] pending_d;
  logic [NUM_PORTS-1:0] grant_vec;
  logic                 grant_valid;
  logic [PortW-1:0]     grant_idx;
  logic [PortW-1:0]     cand;
  int unsigned          cand_int;
  logic                 pop;
  logic                 can_push;
  logic [3:0]           ndrop;
  logic [16:0]          drop_sum;
  logic [15:0]          drop_d;

  assign m_evt_tvalid = (level_q != '0);
  assign m_evt_tdata  = mem_q[rd_ptr_q];
  assign ts_o         = ts_q;
  assign fifo_level_o = level_q;
  assign drop_count_o = drop_q;

  assign pop      = m_evt_tvalid & m_evt_tready;
  // A slot freed by a same-cycle pop can be refilled in that cycle.
  assign can_push = (level_q < DepthLvl) | pop;

  // Free-running timestamp, wraps naturally at 2^TS_WIDTH.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // Per-port pulse qualification: enabled, unmasked and outside the holdoff window.
  always_comb begin
    hold_idle = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hold_idle[p] = (hold_q[p] == '0);
    end
    eligible  = det_pulse_i & port_mask_i & {NUM_PORTS{enable_i}} & hold_idle;
    // A port granted this cycle frees its slot, so a new pulse there is captured.
    capture   = eligible & (~pending_q | grant_vec);
    drop_vec  = eligible & pending_q & ~grant_vec;
    pending_d = eligible | (pending_q & ~grant_vec);
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_int    = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand_int = 32'(rr_q) + i;
      if (cand_int >= NUM_PORTS) begin
        cand_int = cand_int - NUM_PORTS;
      end
      cand = PortW'(cand_int);
      if (can_push && !grant_valid && pending_q[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_vec = grant_valid ? (NUM_PORTS'(1) << grant_idx) : '0;
  end

  // Holdoff counters reload on every eligible pulse (even a dropped one).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        hold_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (eligible[p]) begin
          hold_q[p] <= HoldLoad;
        end else if (hold_q[p] != '0) begin
          hold_q[p] <= hold_q[p] - HoldW'(1);
        end
      end
    end
  end

  // Pending flags and captured timestamps.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cap_ts_q[p] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (capture[p]) begin
          cap_ts_q[p] <= ts_q;
        end
      end
    end
  end

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_q <= RrReset;
    end else if (grant_valid) begin
      rr_q <= grant_idx;
    end
  end

  // Event FIFO storage and pointers; output word is read straight from storage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (grant_valid) begin
        mem_q[wr_ptr_q] <= {8'(grant_idx), cap_ts_q[grant_idx]};
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      if (grant_valid && !pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (!grant_valid && pop) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  // Saturating drop counter; clear wins over a same-cycle increment.
  always_comb begin
    ndrop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      ndrop = ndrop + 4'(drop_vec[p]);
    end
    drop_sum = {1'b0, drop_q} + 17'(ndrop);
    if (drop_clear_i) begin
      drop_d = '0;
    end else if (drop_sum[16]) begin
      drop_d = 16'hFFFF;
    end else begin
      drop_d = drop_sum[15:0];
    end
  end

  // Drop counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_sync_event_scheduler.sv
// Bench for sync_event_scheduler: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_sync_event_scheduler;

  localparam int NP    = 3;
  localparam int TSW   = 8;
  localparam int HOLD  = 16;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NP-1:0] det;
  logic          en;
  logic [NP-1:0] mask;
  logic          clr;
  logic          tvalid;
  logic [15:0]   tdata;
  logic          rdy;
  logic [7:0]    ts;
  logic [2:0]    level;
  logic [15:0]   drops;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_pend    [NP];
  int          m_pend_ts [NP];
  int          m_last    [NP];
  int          m_rr;
  int          m_ts;
  int          m_cyc;
  int          m_drops;
  logic [15:0] mq[$];

  always #5 aclk = ~aclk;

  sync_event_scheduler #(
    .NUM_PORTS      (NP),
    .TS_WIDTH       (TSW),
    .HOLDOFF_CYCLES (HOLD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .det_pulse_i  (det),
    .enable_i     (en),
    .port_mask_i  (mask),
    .drop_clear_i (clr),
    .m_evt_tvalid (tvalid),
    .m_evt_tdata  (tdata),
    .m_evt_tready (rdy),
    .ts_o         (ts),
    .fifo_level_o (level),
    .drop_count_o (drops)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_pend[p]    = 1'b0;
      m_pend_ts[p] = 0;
      m_last[p]    = -1000000;
    end
    m_rr    = NP - 1;
    m_ts    = 0;
    m_cyc   = 0;
    m_drops = 0;
    mq.delete();
  endtask

  // One clock edge of the reference model, using the inputs held across the edge.
  task automatic model_step();
    bit          pop;
    bit          can_push;
    int          g;
    int          c;
    int          inc;
    bit          el [NP];
    logic [15:0] ev;
    for (int p = 0; p < NP; p++) begin
      el[p] = det[p] && en && mask[p] && ((m_cyc - m_last[p]) > HOLD);
    end
    pop      = (mq.size() != 0) && rdy;
    can_push = (mq.size() < DEPTH) || pop;
    g = -1;
    if (can_push) begin
      for (int k = 1; k <= NP; k++) begin
        c = (m_rr + k) % NP;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      ev = {8'(g), 8'(m_pend_ts[g])};
      mq.push_back(ev);
      m_pend[g] = 1'b0;
      m_rr      = g;
    end
    inc = 0;
    for (int p = 0; p < NP; p++) begin
      if (el[p]) begin
        if (m_pend[p]) begin
          inc++;
        end else begin
          m_pend[p]    = 1'b1;
          m_pend_ts[p] = m_ts;
        end
        m_last[p] = m_cyc;
      end
    end
    if (clr) m_drops = 0;
    else m_drops = (m_drops + inc > 65535) ? 65535 : m_drops + inc;
    m_cyc++;
    m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  task automatic compare_all();
    check("ts", 64'(ts), 64'(m_ts));
    check("tvalid", 64'(tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) check("tdata", 64'(tdata), 64'(mq[0]));
    check("level", 64'(level), 64'(mq.size()));
    check("drops", 64'(drops), 64'(m_drops));
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse(input logic [NP-1:0] v);
    det = v;
    tick();
    det = '0;
  endtask

  task automatic run_to(input int t);
    for (int n = 0; n < 600 && m_ts != t; n++) tick();
  endtask

  initial begin
    int pct;
    aresetn = 1'b0;
    det     = '0;
    en      = 1'b1;
    mask    = '1;
    clr     = 1'b0;
    rdy     = 1'b1;
    model_reset();
    #2;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_drops", 64'(drops), 64'd0);
    check("rst_ts", 64'(ts), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Simultaneous pulses: port 0 first after reset, then RR moves on.
    run_to(50);
    pulse(3'b011);
    tick();
    check("rr_first", 64'(tdata), 64'h0032);
    tick();
    check("rr_second", 64'(tdata), 64'h0132);
    run_to(80);
    pulse(3'b101);
    tick();
    check("rr_rot_first", 64'(tdata), 64'h0250);
    tick();
    check("rr_rot_second", 64'(tdata), 64'h0050);

    // Single pulse latency.
    run_to(100);
    pulse(3'b010);
    check("lat_not_yet", 64'(tvalid), 64'd0);
    tick();
    check("lat_valid", 64'(tvalid), 64'd1);
    check("lat_data", 64'(tdata), 64'h0164);
    tick();
    check("lat_level0", 64'(level), 64'd0);

    // Holdoff: 10 accepted, 20 suppressed, 27 accepted.
    run_to(10);
    pulse(3'b001);
    tick();
    check("hold_first", 64'(tdata), 64'h000A);
    run_to(20);
    pulse(3'b001);
    tick();
    check("hold_suppressed", 64'(tvalid), 64'd0);
    run_to(27);
    pulse(3'b001);
    tick();
    check("hold_third", 64'(tdata), 64'h001B);
    check("hold_nodrop", 64'(drops), 64'd0);

    // Timestamp wrap.
    run_to(255);
    pulse(3'b001);
    pulse(3'b010);
    check("wrap_255", 64'(tdata), 64'h00FF);
    tick();
    check("wrap_0", 64'(tdata), 64'h0100);
    repeat (3) tick();

    // Overflow: FIFO full plus one pending, the next pulse is dropped.
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse(3'b100);
      repeat (16) tick();
    end
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_drops", 64'(drops), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("drop_clear", 64'(drops), 64'd0);
    rdy = 1'b1;
    repeat (10) tick();
    check("ovf_drained", 64'(level), 64'd0);

    // Reset with three queued and one pending event.
    rdy = 1'b0;
    pulse(3'b111);
    repeat (3) tick();
    check("pre_rst_level", 64'(level), 64'd3);
    repeat (13) tick();
    pulse(3'b001);
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_ts", 64'(ts), 64'd0);
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rdy = 1'b1;
    repeat (40) tick();

    // Randomized traffic with varying consumer throughput.
    for (int seg = 0; seg < 12; seg++) begin
      pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int n = 0; n < 250; n++) begin
        for (int p = 0; p < NP; p++) det[p] = ($urandom_range(0, 3) == 0);
        en  = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 31) == 0) mask = NP'($urandom);
        clr = ($urandom_range(0, 63) == 0);
        rdy = ($urandom_range(0, 99) < pct);
        tick();
      end
    end
    det = '0;
    clr = 1'b0;
    rdy = 1'b1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
